// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down counter slice.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10
    } counter_mode_e;

    localparam int unsigned GRAY_MAXW = 32;

    function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE; tick is high while the prescaler sits at PRESCALE-1.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/updown_counter.sv
// Parametrised modulo-N up/down counter with prescaler, load, wrap/saturate/one-shot
// modes, terminal-count pulse, sticky overflow and registered Gray output.
module updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MODULUS  = 256,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             ovf,
    output logic             done
);

    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $error("updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("updown_counter: PRESCALE must be >= 1");
    end

    localparam logic [WIDTH-1:0] QMAX      = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   QMAX_WIDE = (WIDTH+1)'(MODULUS - 1);

    logic          tick;
    logic          at_bound;
    logic          bound_tick;
    counter_mode_e mode_e;

    logic [WIDTH-1:0] q_n;
    logic             tc_n;
    logic             ovf_n;
    logic             done_n;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .restart(clear | load),
        .tick   (tick)
    );

    assign mode_e     = counter_mode_e'(mode);
    assign at_bound   = up ? (q == QMAX) : (q == '0);
    assign bound_tick = tick && !done && !clear && !load && at_bound;

    always_comb begin
        q_n    = q;
        tc_n   = 1'b0;
        done_n = done;
        ovf_n  = bound_tick ? 1'b1 : (ovf && !ovf_clr);

        if (clear) begin
            q_n    = '0;
            done_n = 1'b0;
        end else if (load) begin
            q_n    = ({1'b0, load_val} > QMAX_WIDE) ? QMAX : load_val;
            done_n = 1'b0;
        end else if (tick && !done) begin
            if (at_bound) begin
                tc_n = 1'b1;
                case (mode_e)
                    MODE_SAT:     q_n = q;
                    MODE_ONESHOT: done_n = 1'b1;
                    // reserved encoding falls through to wrap
                    default:      q_n = up ? '0 : QMAX;
                endcase
            end else begin
                q_n = up ? q + 1'b1 : q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            gray <= '0;
            tc   <= 1'b0;
            ovf  <= 1'b0;
            done <= 1'b0;
        end else begin
            q    <= q_n;
            gray <= WIDTH'(bin2gray(GRAY_MAXW'(q_n)));
            tc   <= tc_n;
            ovf  <= ovf_n;
            done <= done_n;
        end
    end

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench: two counters (PRESCALE 1 and 3, WIDTH 4, MODULUS 10) against a behavioural model.
module tb_updown_counter;

    localparam int W   = 4;
    localparam int MOD = 10;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] gray;
        logic         tc;
        logic         ovf;
        logic         done;
    } obs_t;

    typedef struct {
        int q;
        int ps;
        int ovf;
        int done;
        int tc;
    } model_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0, en = 1'b0, up = 1'b1, clear = 1'b0, load = 1'b0, ovf_clr = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] load_val = '0;

    logic [W-1:0] q1, g1, q3, g3;
    logic         tc1, ovf1, done1, tc3, ovf3, done3;

    obs_t exp1_q[$];
    obs_t exp3_q[$];
    model_t m1, m3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(W), .MODULUS(MOD), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .mode(mode), .clear(clear),
        .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
        .q(q1), .gray(g1), .tc(tc1), .ovf(ovf1), .done(done1)
    );

    updown_counter #(.WIDTH(W), .MODULUS(MOD), .PRESCALE(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .up(up), .mode(mode), .clear(clear),
        .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
        .q(q3), .gray(g3), .tc(tc3), .ovf(ovf3), .done(done3)
    );

    // Reference behaviour: one clock of the counter described in plain arithmetic.
    function automatic model_t step(input model_t s, input int p);
        model_t n = s;
        int lv = int'(load_val);
        bit tick, boundary;
        n.tc = 0;
        if (rst) begin
            n.q = 0; n.ps = 0; n.ovf = 0; n.done = 0;
        end else if (clear) begin
            n.q = 0; n.ps = 0; n.done = 0;
            if (ovf_clr) n.ovf = 0;
        end else if (load) begin
            n.q = (lv > MOD - 1) ? MOD - 1 : lv;
            n.ps = 0; n.done = 0;
            if (ovf_clr) n.ovf = 0;
        end else begin
            tick = en && (s.ps == p - 1);
            if (en) n.ps = (s.ps + 1) % p;
            boundary = 0;
            if (tick && s.done == 0) begin
                boundary = up ? (s.q == MOD - 1) : (s.q == 0);
                if (boundary) begin
                    n.tc = 1;
                    if (mode == 2'b10) n.done = 1;
                    else if (mode != 2'b01) n.q = up ? 0 : MOD - 1;
                end else begin
                    n.q = up ? s.q + 1 : s.q - 1;
                end
            end
            if (boundary) n.ovf = 1;
            else if (ovf_clr) n.ovf = 0;
        end
        return n;
    endfunction

    function automatic obs_t to_obs(input model_t s);
        obs_t o;
        o.q    = W'(s.q);
        o.gray = W'(s.q ^ (s.q >> 1));
        o.tc   = s.tc[0];
        o.ovf  = s.ovf[0];
        o.done = s.done[0];
        return o;
    endfunction

    task automatic cyc(input bit r, input bit e, input bit u, input logic [1:0] md,
                       input bit c, input bit l, input logic [W-1:0] lv, input bit oc);
        rst = r; en = e; up = u; mode = md; clear = c; load = l; load_val = lv; ovf_clr = oc;
        @(posedge clk);
        m1 = step(m1, 1);
        m3 = step(m3, 3);
        exp1_q.push_back(to_obs(m1));
        exp3_q.push_back(to_obs(m3));
        #1;
    endtask

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got q=%0d gray=%b tc=%b ovf=%b done=%b, want q=%0d gray=%b tc=%b ovf=%b done=%b",
                     name, act.q, act.gray, act.tc, act.ovf, act.done,
                     exp.q, exp.gray, exp.tc, exp.ovf, exp.done);
        end
    endtask

    // Monitor: outputs are valid every cycle once a stimulus cycle has been issued.
    initial begin
        forever begin
            @(negedge clk);
            if (exp1_q.size() > 0) check("prescale1", '{q1, g1, tc1, ovf1, done1}, exp1_q.pop_front());
            if (exp3_q.size() > 0) check("prescale3", '{q3, g3, tc3, ovf3, done3}, exp3_q.pop_front());
        end
    end

    initial begin
        m1 = '{0, 0, 0, 0, 0};
        m3 = '{0, 0, 0, 0, 0};
        @(negedge clk);

        // reset then wrap up
        cyc(1, 0, 1, 2'b00, 0, 0, '0, 0);
        for (int i = 0; i < 12; i++) cyc(0, 1, 1, 2'b00, 0, 0, '0, 0);

        // down and saturate, then ovf_clr without a tick
        cyc(0, 0, 0, 2'b01, 0, 1, W'(2), 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 2'b01, 0, 0, '0, 0);
        cyc(0, 0, 0, 2'b01, 0, 0, '0, 1);

        // one-shot, then reload resumes
        cyc(0, 0, 1, 2'b10, 0, 1, W'(7), 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 2'b10, 0, 0, '0, 0);
        cyc(0, 0, 1, 2'b10, 0, 1, W'(3), 0);
        for (int i = 0; i < 2; i++) cyc(0, 1, 1, 2'b10, 0, 0, '0, 0);

        // prescale run with an enable gap
        cyc(0, 0, 1, 2'b00, 1, 0, '0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 1, 2'b00, 0, 0, '0, 0);
        for (int i = 0; i < 2; i++) cyc(0, 0, 1, 2'b00, 0, 0, '0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 2'b00, 0, 0, '0, 0);

        // priority, clamp, ovf_clr colliding with a wrap tick
        cyc(0, 1, 1, 2'b00, 1, 1, W'(15), 0);
        cyc(0, 0, 1, 2'b00, 0, 1, W'(15), 0);
        cyc(0, 0, 1, 2'b00, 0, 0, '0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 2'b00, 0, 0, '0, 1);

        // reset mid one-shot with prescaler mid-count
        cyc(0, 0, 1, 2'b10, 0, 1, W'(8), 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 1, 2'b10, 0, 0, '0, 0);
        cyc(1, 1, 1, 2'b10, 0, 0, '0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 2'b00, 0, 0, '0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r = $urandom_range(0, 99);
            cyc(r < 1, $urandom_range(0, 99) < 80, (i % 40 < 25) ? $urandom_range(0, 9) != 0 : $urandom_range(0, 9) == 0,
                2'($urandom_range(0, 3)), r >= 1 && r < 3, r >= 3 && r < 7,
                W'($urandom_range(0, 15)), $urandom_range(0, 99) < 6);
        end

        for (int i = 0; i < 10 && (exp1_q.size() > 0 || exp3_q.size() > 0); i++) @(negedge clk);
        @(negedge clk);
        if (exp1_q.size() > 0 || exp3_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", exp1_q.size(), exp3_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
